// File: rtl/hazard_controller_if.sv
// Decode-side bundle between the pipeline and the hazard controller.
interface hazard_controller_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        redirect;
    logic        issue;
    logic        stall;
    logic        flush;
    logic        ex_bubble;
    logic [1:0]  state;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output id_valid, id_instr, redirect,
        input  issue, stall, flush, ex_bubble, state, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_instr, redirect,
        output issue, stall, flush, ex_bubble, state, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Sequencing controller beside decode: stalls on RAW hazards against the
// EX/MEM/WB destination scoreboard (no forwarding), squashes wrong-path
// instructions after a redirect, and keeps saturating stall/flush statistics.
module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic                clock,
    input logic                reset_n,
    hazard_controller_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } slot_t;

    localparam slot_t      EMPTY      = '{valid: 1'b0, rd: 5'd0};
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_q;
    logic [2:0]  flush_left;
    slot_t       slot_ex, slot_mem, slot_wb;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic        writes_rd, reads_rs1, reads_rs2;
    logic        rs1_hit, rs2_hit;
    logic        hazard, squash;
    logic        issue_c, stall_c;
    logic        unused_fields;

    assign opcode = bus.id_instr[6:0];
    assign rd     = bus.id_instr[11:7];
    assign rs1    = bus.id_instr[19:15];
    assign rs2    = bus.id_instr[24:20];
    assign unused_fields = ^{bus.id_instr[31:25], bus.id_instr[14:12]};

    function automatic logic pending(input logic [4:0] rs, input slot_t s);
        return s.valid && (s.rd == rs);
    endfunction

    // Decode which register fields the ID instruction actually uses.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        writes_rd = 1'b0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        case (opcode)
            7'b0110011: begin writes_rd = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1; end // OP
            7'b0010011,                                                                 // OP-IMM
            7'b0000011,                                                                 // LOAD
            7'b1100111: begin writes_rd = 1'b1; reads_rs1 = 1'b1; end                   // JALR
            7'b0100011,                                                                 // STORE
            7'b1100011: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end                   // BRANCH
            7'b1101111,                                                                 // JAL
            7'b0110111,                                                                 // LUI
            7'b0010111: writes_rd = 1'b1;                                               // AUIPC
            default:    ;
        endcase
    end

    // WB counts as a hit because the register file has no write-through.
    assign rs1_hit = reads_rs1 && (rs1 != 5'd0) &&
                     (pending(rs1, slot_ex) || pending(rs1, slot_mem) || pending(rs1, slot_wb));
    assign rs2_hit = reads_rs2 && (rs2 != 5'd0) &&
                     (pending(rs2, slot_ex) || pending(rs2, slot_mem) || pending(rs2, slot_wb));

    // Everything is gated by reset_n so the outputs are quiet while reset is held.
    assign hazard  = reset_n && bus.id_valid && (rs1_hit || rs2_hit);
    assign squash  = reset_n && (bus.redirect || (state_q == FLUSH));
    assign stall_c = !squash && hazard;
    assign issue_c = !squash && !hazard && reset_n && bus.id_valid;

    assign bus.issue       = issue_c;
    assign bus.stall       = stall_c;
    assign bus.flush       = squash;
    assign bus.ex_bubble   = squash || hazard;
    assign bus.state       = state_q;
    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = redirect_cnt;

    // Sequencing FSM: redirect (re)arms the flush window, otherwise track stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            flush_left <= 3'd0;
        end else if (bus.redirect && (FLUSH_CYCLES != 0)) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= FLUSH;
            flush_left <= FLUSH_LOAD;
        end else if (state_q == FLUSH) begin
            if (flush_left <= 3'd1) begin
                state_q    <= RUN;
                flush_left <= 3'd0;
            end else begin
                flush_left <= flush_left - 3'd1;
            end
        end else begin
            state_q <= stall_c ? STALL : RUN;
        end
    end

    // Destination scoreboard: older slots always drain, EX takes only issued work.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_ex  <= EMPTY;
            slot_mem <= EMPTY;
            slot_wb  <= EMPTY;
        end else begin
            slot_wb  <= slot_mem;
            slot_mem <= slot_ex;
            slot_ex  <= issue_c ? '{valid: writes_rd && (rd != 5'd0), rd: rd} : EMPTY;
        end
    end

    // Saturating statistics: stall cycles and redirect events.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt    <= 16'd0;
            redirect_cnt <= 16'd0;
        end else begin
            if (stall_c && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (bus.redirect && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage RISC-V core. It sits beside the decode stage and tracks the destination registers of instructions in flight in EX, MEM and WB. It stalls fetch/decode on read-after-write hazards, since the pipeline has no forwarding. It squashes wrong-path instructions after a taken branch or jump and keeps saturating stall/flush statistics.

## Interface
- FLUSH_CYCLES, default 1: extra cycles after the redirect cycle during which the ID instruction is squashed (covers fetch latency); legal 0-7.
- clock  in  1  rising-edge system clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds an instruction.
- id_instr  in  32  raw instruction in ID; 32'd0 is NOP.
- redirect  in  1  one-cycle pulse from EX: branch taken, JAL or JALR resolved.
- issue  out  1  ID instruction advances into EX this cycle.
- stall  out  1  hold PC and the IF/ID register.
- flush  out  1  clear the IF/ID register at the next edge.
- ex_bubble  out  1  load a bubble into ID/EX.
- state  out  2  00 RUN, 01 STALL, 10 FLUSH.
- stall_count  out  16  saturating count of stall cycles.
- flush_count  out  16  saturating count of redirect events.

## Operation
- Operand use is decoded from id_instr[6:0]:
  - Writes rd: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111.
  - Reads rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - Reads rs2: 0110011, 0100011, 1100011.
  - All other opcodes, including NOP, read and write nothing.
- Scoreboard: three registered slots EX, MEM, WB, each holding {valid, rd[4:0]}. A slot is valid only if the instruction writes rd and rd != 0.
- Hazard: id_valid AND a used source (rs != 0) equals a valid slot's rd. The WB slot counts because the register file has no write-through.
- Per-cycle slot shift: WB <= MEM, MEM <= EX. EX <= the ID instruction's {writes && rd != 0, rd} when issue=1, else invalid.
- Priority of combinational outputs:
  1. redirect=1 or state=FLUSH: flush=1, ex_bubble=1, issue=0, stall=0.
  2. Otherwise, hazard: stall=1, ex_bubble=1, issue=0.
  3. Otherwise: issue=id_valid; all others 0.
- State machine:
  - RUN -> STALL on hazard.
  - STALL -> RUN when the hazard clears.
  - Any state -> FLUSH on redirect if FLUSH_CYCLES > 0. Load the counter with FLUSH_CYCLES.
  - In FLUSH, decrement the counter each cycle. Return to RUN when it reaches 1 and there is no redirect.
  - Redirect while in FLUSH reloads the counter.
  - With FLUSH_CYCLES = 0, redirect squashes only the current cycle and the state stays RUN/STALL per hazard.
- Counters:
  - stall_count increments on each cycle with stall=1.
  - flush_count increments on each cycle with redirect=1.
  - Both saturate at 16'hFFFF.
- Redirect during a stall: the stalled instruction is wrong-path and is discarded. Slots already in EX/MEM/WB drain normally; they are older and valid.

## Timing
- Reset (async, reset_n=0): all slots invalid, state=RUN (00), flush counter 0, stall_count=0, flush_count=0.
- issue, stall, flush and ex_bubble are combinational from current inputs and registered state. With reset asserted, id_valid is ignored, so all four are 0.
- Reset deassertion takes effect at the first rising edge after release.
- Stall latency by producer position: 3 cycles when the producer is in EX, 2 when in MEM, 1 when in WB. The consumer issues in the cycle after the producer leaves WB.
- Redirect at cycle t: flush=1 at t. With FLUSH_CYCLES = N, squashing continues through cycle t+N. The earliest issue is at t+N+1.
- Reset mid-stall or mid-flush: state and scoreboard are lost immediately. The controller resumes in RUN with an empty scoreboard.

## Test plan
- Back-to-back RAW: issue 0x002081B3 (add x3,x1,x2), then 0x00118213 (addi x4,x3,1) -> stall=1 for exactly 3 cycles, issue on the 4th, stall_count=3.
- Independent pair: 0x002081B3 then 0x00302023 (sw x3,0(x0)) separated by three NOPs (32'd0) -> no stall; issue every valid cycle.
- x0 destination: 0x00000013 (addi x0,x0,0) then 0x00000213 (addi x4,x0,0) -> no stall.
- Redirect with FLUSH_CYCLES=2: pulse redirect at cycle 10 -> flush=1 in cycles 10-12, issue=0, state=10 during 11-12, flush_count=1, RUN at 13.
- Redirect during stall: hazard stall in progress, redirect pulse -> stall drops the same cycle, flush=1. The scoreboard still drains; a later dependent instruction stalls only for the remaining slots.
- Async reset mid-FLUSH and saturation: assert reset_n=0 in FLUSH -> state=00 and counters 0 without a clock edge. Preload to 16'hFFFE and apply 3 stall cycles -> stall_count holds at 16'hFFFF.
